car_light_sequencer: RTL
========================

# car_light_sequencer

Sequencing controller for the car's light controller. Arbitrates the stalk and hazard requests into the 2-bit external-light select and generates the indicator flash waveform that drives the external lights. Also generates the 2-bit interior-light select, adding a timed courtesy hold after the doors close. Sits between the driver switches and the interior/exterior light blocks, replacing their direct switch wiring.

## Interface
- `BLINK_HALF`, 8, cycles per flash half-period (on time = off time); must be ≥ 2
- `COURTESY_CYCLES`, 16, cycles the interior light is held on after the last door closes; must be ≥ 1
- `clk` input 1 system clock, all state on rising edge
- `rst_n` input 1 reset, asynchronous assert, active-low
- `req_left` input 1 left indicator stalk, level
- `req_right` input 1 right indicator stalk, level
- `req_hazard` input 1 hazard button, level
- `key` input 1 key switch
- `door` input 4 door switches, 1 = open
- `sw_int` input 2 interior main switch: 0 ON, 1 DOOR, 2/3 OFF
- `select_ext` output 2 external select: 0 off, 1 right, 2 left, 3 both
- `flash` output 1 indicator flash waveform, to the external-light clock input
- `select_int` output 2 interior select, same encoding as `sw_int`

## Operation
- Indicator FSM states: IDLE, LEFT, RIGHT, HAZARD.
  - IDLE drives `select_ext` = 0.
  - LEFT drives 2, RIGHT drives 1, HAZARD drives 3.
- Requests are arbitrated every cycle, in priority order:
  1. `req_hazard` → HAZARD.
  2. `req_left` alone → LEFT.
  3. `req_right` alone → RIGHT.
  4. Left and right both high without hazard: treated as no request.
- Any state change into a non-IDLE state restarts the flash phase. This covers IDLE→active, LEFT↔RIGHT, entering HAZARD, and leaving HAZARD into LEFT/RIGHT.
  - On restart: `flash` = 1, phase counter = 0, on-phase counter = 0.
- Phase counter, width $clog2(BLINK_HALF):
  - Counts 0..BLINK_HALF-1 and wraps.
  - `flash` toggles on wrap.
  - The on-phase counter (2 bits, saturating at 3) increments each time `flash` falls.
- Leaving to IDLE: `flash` = 0 and `select_ext` = 0 in the same cycle.
- Hazard release with a single stalk still held goes directly to that side, with the phase restarted.
- Interior FSM states: PASS, HOLD.
  - PASS: `select_int` = `sw_int`.
  - HOLD: `select_int` = 0 (forced ON), and the courtesy counter (width $clog2(COURTESY_CYCLES+1)) counts up from 0.
- PASS→HOLD happens when all three hold in one cycle:
  - `door` goes from non-zero to zero (registered previous value).
  - `sw_int` == 1.
  - `key` == 0.
- HOLD→PASS happens when any of these occurs:
  - Courtesy counter reaches COURTESY_CYCLES-1.
  - `key` == 1.
  - `sw_int` != 1.
  - Any door reopens.
- All exits from HOLD resume pass-through on the next cycle.

## Timing
- Reset values (asynchronous, while `rst_n` = 0):
  - `select_ext` = 0, `flash` = 0, `select_int` = 2.
  - Both FSMs in IDLE/PASS, all counters 0.
  - Previous-door register = 0, so a door already open at reset does not trigger HOLD.
- All outputs are registered. Inputs sampled at edge t appear on the outputs after edge t (latency 1).
- `flash` period is exactly 2·BLINK_HALF cycles. The first on-phase lasts BLINK_HALF cycles beginning the cycle after the request is sampled.
- HOLD lasts exactly COURTESY_CYCLES cycles of `select_int` = 0, unless aborted.
- Reset deasserted mid-flash or mid-HOLD: the block restarts from the reset state. There is no resume.
- Same-cycle door close and key on: key wins, no HOLD.

## Configuration
- `COMFORT_FLASH_EN` defined: LEFT/RIGHT is held after the request drops until 3 on-phases have completed.
  - The state exits to IDLE on the cycle `flash` would fall for the third time.
  - If 3 on-phases are already complete, it exits immediately.
  - A new opposite-side or hazard request preempts the hold.
  - HAZARD always exits immediately.
- `COMFORT_FLASH_EN` not defined: a dropped request returns to IDLE on the next edge.
  - The on-phase counter is not implemented.

## Test plan
- Reset with `door`=4'b0001, `sw_int`=1: outputs 0/0/2 during reset. After release, `select_int`=1 and no HOLD.
- BLINK_HALF=4, `req_left` held 20 cycles:
  - `select_ext`=2 from the next cycle.
  - `flash` pattern 1111 0000 repeating.
  - On release, IDLE next cycle with `flash`=0. With `COMFORT_FLASH_EN`, a 1-cycle pulse yields exactly 3 four-cycle on-phases.
- LEFT active, `req_hazard` asserted mid off-phase: `select_ext`=3 and `flash`=1 next cycle, phase restarted. On hazard release with left still held, returns to `select_ext`=2 with `flash`=1.
- `req_left` and `req_right` both high: `select_ext` stays 0 and `flash` stays 0.
- COURTESY_CYCLES=10, `sw_int`=1, `key`=0, `door` 4'b0100→0: `select_int`=0 for exactly 10 cycles, then 1.
- Same setup, `key` set in cycle 5 of HOLD: `select_int` returns to 1 on the next cycle.

Source files
------------

// File: rtl/car_light_sequencer_if.sv
// ---------------------------------------------------------------------------
// car_light_sequencer_if
//
// Groups the driver-switch inputs and the light-select outputs of the car
// light sequencer into one bundle.
//
//   req_left   : left indicator stalk, level
//   req_right  : right indicator stalk, level
//   req_hazard : hazard button, level
//   key        : key switch
//   door[3:0]  : door switches, 1 = open
//   sw_int[1:0]: interior main switch (0 ON, 1 DOOR, 2/3 OFF)
//   select_ext : external select (0 off, 1 right, 2 left, 3 both)
//   flash      : indicator flash waveform
//   select_int : interior select, same encoding as sw_int
//
// Modports:
//   master : switch side, drives the requests and observes the selects
//   slave  : the sequencer, consumes the requests and drives the selects
// ---------------------------------------------------------------------------
interface car_light_sequencer_if;
  logic       req_left;
  logic       req_right;
  logic       req_hazard;
  logic       key;
  logic [3:0] door;
  logic [1:0] sw_int;
  logic [1:0] select_ext;
  logic       flash;
  logic [1:0] select_int;

  modport master (
    output req_left,
    output req_right,
    output req_hazard,
    output key,
    output door,
    output sw_int,
    input  select_ext,
    input  flash,
    input  select_int
  );

  modport slave (
    input  req_left,
    input  req_right,
    input  req_hazard,
    input  key,
    input  door,
    input  sw_int,
    output select_ext,
    output flash,
    output select_int
  );
endinterface

// File: rtl/car_light_sequencer.sv
// ---------------------------------------------------------------------------
// car_light_sequencer
//
// Arbitrates the indicator stalk and hazard button into the external-light
// select and generates the indicator flash waveform. Independently produces
// the interior-light select, holding the interior light on for a courtesy
// period after the last door closes while the main switch is in DOOR.
//
// Parameters:
//   BLINK_HALF      : cycles per flash half-period (>= 2)
//   COURTESY_CYCLES : cycles the interior light stays on after doors close (>= 1)
//
// Ports:
//   clk   : system clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : car_light_sequencer_if.slave (requests in, selects/flash out)
//
// Optional feature macro: COMFORT_FLASH_EN
//   When defined, a dropped left/right request keeps the indicator running
//   until three on-phases have completed. When undefined the indicator
//   follows the request directly and the on-phase counter is absent.
//
// All outputs are registered: inputs sampled at edge t are visible after t.
// ---------------------------------------------------------------------------
module car_light_sequencer #(
  parameter int BLINK_HALF      = 8,
  parameter int COURTESY_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  car_light_sequencer_if.slave        bus
);

  localparam int PW = $clog2(BLINK_HALF);
  localparam int CW = $clog2(COURTESY_CYCLES + 1);

  localparam logic [PW-1:0] PHASE_ZERO = PW'(0);
  localparam logic [PW-1:0] PHASE_ONE  = PW'(1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(BLINK_HALF - 1);
  localparam logic [CW-1:0] HOLD_ZERO  = CW'(0);
  localparam logic [CW-1:0] HOLD_ONE   = CW'(1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(COURTESY_CYCLES - 1);

  // State values equal the external select code they drive.
  typedef enum logic [1:0] {
    IND_IDLE   = 2'd0,
    IND_RIGHT  = 2'd1,
    IND_LEFT   = 2'd2,
    IND_HAZARD = 2'd3
  } ind_state_e;

  typedef enum logic {
    INT_PASS = 1'b0,
    INT_HOLD = 1'b1
  } int_state_e;

  // Indicator path
  ind_state_e     ind_state_q, ind_state_d;
  ind_state_e     req_target_s;
  ind_state_e     ind_next_s;
  logic [PW-1:0]  phase_q, phase_d;
  logic           flash_q, flash_d;
  logic [1:0]     select_ext_q, select_ext_d;
  logic           phase_wrap_s;

`ifdef COMFORT_FLASH_EN
  logic [1:0]     onph_q, onph_d;
  logic           flash_fall_s;
`endif

  // Interior path
  int_state_e     int_state_q, int_state_d;
  logic [CW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [3:0]     door_prev_q, door_prev_d;
  logic [1:0]     select_int_q, select_int_d;
  logic           door_close_s;

  // -------------------------------------------------------------------------
  // Indicator
  // -------------------------------------------------------------------------

  assign phase_wrap_s = (phase_q == PHASE_LAST);

  // Request arbitration: hazard first, then a single stalk; both stalks
  // together without hazard is treated as no request.
  always_comb begin
    if (bus.req_hazard) begin
      req_target_s = IND_HAZARD;
    end else if (bus.req_left && !bus.req_right) begin
      req_target_s = IND_LEFT;
    end else if (bus.req_right && !bus.req_left) begin
      req_target_s = IND_RIGHT;
    end else begin
      req_target_s = IND_IDLE;
    end
  end

`ifdef COMFORT_FLASH_EN
  assign flash_fall_s = flash_q && phase_wrap_s;

  // Next indicator state: a dropped left/right request is held until the
  // third on-phase ends (exit lands on the edge where flash would fall).
  // Any new non-idle request, and any hazard release, goes straight through.
  always_comb begin
    ind_next_s = req_target_s;
    if ((req_target_s == IND_IDLE) &&
        ((ind_state_q == IND_LEFT) || (ind_state_q == IND_RIGHT))) begin
      if ((onph_q == 2'd3) || (flash_fall_s && (onph_q == 2'd2))) begin
        ind_next_s = IND_IDLE;
      end else begin
        ind_next_s = ind_state_q;
      end
    end else begin
      ind_next_s = req_target_s;
    end
  end

  // Completed on-phase counter, saturating at 3; cleared on every restart.
  always_comb begin
    onph_d = onph_q;
    if ((ind_next_s == IND_IDLE) || (ind_next_s != ind_state_q)) begin
      onph_d = 2'd0;
    end else if (flash_fall_s && (onph_q != 2'd3)) begin
      onph_d = onph_q + 2'd1;
    end else begin
      onph_d = onph_q;
    end
  end

  // On-phase counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onph_q <= 2'd0;
    end else begin
      onph_q <= onph_d;
    end
  end
`else
  // Next indicator state follows the arbitrated request directly.
  always_comb begin
    ind_next_s = req_target_s;
  end
`endif

  // Flash phase generation and external select. Entering any non-idle state
  // from a different state restarts the waveform in its on-phase.
  always_comb begin
    ind_state_d  = ind_next_s;
    phase_d      = phase_q;
    flash_d      = flash_q;
    select_ext_d = 2'd0;
    if (ind_next_s == IND_IDLE) begin
      phase_d = PHASE_ZERO;
      flash_d = 1'b0;
    end else if (ind_next_s != ind_state_q) begin
      phase_d = PHASE_ZERO;
      flash_d = 1'b1;
    end else if (phase_wrap_s) begin
      phase_d = PHASE_ZERO;
      flash_d = ~flash_q;
    end else begin
      phase_d = phase_q + PHASE_ONE;
    end

    case (ind_next_s)
      IND_IDLE:   select_ext_d = 2'd0;
      IND_RIGHT:  select_ext_d = 2'd1;
      IND_LEFT:   select_ext_d = 2'd2;
      IND_HAZARD: select_ext_d = 2'd3;
      default:    select_ext_d = 2'd0;
    endcase
  end

  // Indicator state, phase and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ind_state_q  <= IND_IDLE;
      phase_q      <= PHASE_ZERO;
      flash_q      <= 1'b0;
      select_ext_q <= 2'd0;
    end else begin
      ind_state_q  <= ind_state_d;
      phase_q      <= phase_d;
      flash_q      <= flash_d;
      select_ext_q <= select_ext_d;
    end
  end

  // -------------------------------------------------------------------------
  // Interior light
  // -------------------------------------------------------------------------

  // Last door closing: some door open last cycle, all closed now.
  assign door_close_s = (door_prev_q != 4'd0) && (bus.door == 4'd0);

  // Interior FSM: pass the main switch through, or force ON (code 0) for the
  // courtesy period. Key on, leaving DOOR position or reopening a door aborts
  // the hold; key on also blocks entry when it coincides with the close.
  always_comb begin
    int_state_d  = int_state_q;
    hold_cnt_d   = hold_cnt_q;
    select_int_d = bus.sw_int;
    door_prev_d  = bus.door;
    case (int_state_q)
      INT_PASS: begin
        if (door_close_s && (bus.sw_int == 2'd1) && !bus.key) begin
          int_state_d  = INT_HOLD;
          hold_cnt_d   = HOLD_ZERO;
          select_int_d = 2'd0;
        end else begin
          int_state_d  = INT_PASS;
          hold_cnt_d   = HOLD_ZERO;
          select_int_d = bus.sw_int;
        end
      end
      INT_HOLD: begin
        if ((hold_cnt_q == HOLD_LAST) || bus.key ||
            (bus.sw_int != 2'd1) || (bus.door != 4'd0)) begin
          int_state_d  = INT_PASS;
          hold_cnt_d   = HOLD_ZERO;
          select_int_d = bus.sw_int;
        end else begin
          int_state_d  = INT_HOLD;
          hold_cnt_d   = hold_cnt_q + HOLD_ONE;
          select_int_d = 2'd0;
        end
      end
      default: begin
        int_state_d  = INT_PASS;
        hold_cnt_d   = HOLD_ZERO;
        select_int_d = bus.sw_int;
      end
    endcase
  end

  // Interior state, courtesy counter, previous-door and output registers.
  // The previous-door register resets to zero so a door already open at
  // reset cannot look like a close on the first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_state_q  <= INT_PASS;
      hold_cnt_q   <= HOLD_ZERO;
      door_prev_q  <= 4'd0;
      select_int_q <= 2'd2;
    end else begin
      int_state_q  <= int_state_d;
      hold_cnt_q   <= hold_cnt_d;
      door_prev_q  <= door_prev_d;
      select_int_q <= select_int_d;
    end
  end

  assign bus.select_ext = select_ext_q;
  assign bus.flash      = flash_q;
  assign bus.select_int = select_int_q;

endmodule
